// File: rtl/rslt_hex_display.sv
// Converts a 10-bit binary result into four 7-segment digits with a
// shift-and-add-3 converter that only runs when the captured value changes.
module rslt_hex_display #(
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] value,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       busy,
    output logic       valid
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [9:0]  cap_reg;
    logic [9:0]  shift;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic [3:0]  count;
    logic [3:0]  dig0, dig1, dig2, dig3;
    logic        primed;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digit registers are only written in DONE, so partial BCD never reaches the segments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cap_reg <= '0;
            shift   <= '0;
            bcd     <= '0;
            count   <= '0;
            dig0    <= '0;
            dig1    <= '0;
            dig2    <= '0;
            dig3    <= '0;
            primed  <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!primed || (value != cap_reg)) begin
                        cap_reg <= value;
                        shift   <= value;
                        bcd     <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        valid   <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, shift} <= {bcd_adj[14:0], shift, 1'b0};
                    count        <= count + 4'd1;
                    if (count == 4'd9) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    dig0   <= bcd[3:0];
                    dig1   <= bcd[7:4];
                    dig2   <= bcd[11:8];
                    dig3   <= bcd[15:12];
                    primed <= 1'b1;
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // A digit is a leading zero only if it and every more significant digit are zero.
    logic blank3, blank2, blank1;
    assign blank3 = BLANK_LZ && (dig3 == 4'd0);
    assign blank2 = blank3 && (dig2 == 4'd0);
    assign blank1 = blank2 && (dig1 == 4'd0);

    assign hex0 = seg7(dig0);
    assign hex1 = blank1 ? 7'b1111111 : seg7(dig1);
    assign hex2 = blank2 ? 7'b1111111 : seg7(dig2);
    assign hex3 = blank3 ? 7'b1111111 : seg7(dig3);

endmodule
